// File: rtl/fgpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fgpio_pkg
//  Description : Shared defaults and vector types for the FGPIO input
//                conditioning stage (fgpio_in_filter / fgpio_pin_filter).
//  Revision    : 1.0 - initial release
// ============================================================================

package fgpio_pkg;

    // Number of GPIO pins; matches the FGPIO instruction unit pin count.
    localparam int PIN_NUM_DEF = 8;

    // Width of the per-pin debounce counter and of the threshold input.
    localparam int DEB_W_DEF = 4;

    // One bit per pin.
    typedef logic [PIN_NUM_DEF-1:0] fgpio_vec_t;

    // Debounce counter / threshold value.
    typedef logic [DEB_W_DEF-1:0] fgpio_deb_t;

endpackage : fgpio_pkg

`default_nettype wire

// File: rtl/fgpio_pin_filter.sv
`default_nettype none
// ============================================================================
//  Module      : fgpio_pin_filter
//  Description : Single-pin input conditioner: two-flop synchroniser,
//                programmable debounce filter and sticky edge detection.
//                Edge logic is only built when FGPIO_IN_EDGE_EN is defined;
//                otherwise both flag outputs are tied low.
//  Revision    : 1.0 - initial release
// ============================================================================

module fgpio_pin_filter
    import fgpio_pkg::*;
#(
    parameter int DEB_W = DEB_W_DEF
) (
    input  logic             clk_neg_i,
    input  logic             rst_ni,
    input  logic             pad,
    input  logic             dir,
    input  logic             flt_en,
    input  logic [DEB_W-1:0] flt_thresh,
    input  logic             edge_clr,
    output logic             level,
    output logic             rise_flag,
    output logic             fall_flag
);

    // Synchroniser pair; s1 is the only flop that sees the raw pad.
    logic s1;
    logic s2;

    // Filter state: accepted level and consecutive-difference counter.
    logic             q;
    logic             q_next;
    logic [DEB_W-1:0] cnt;
    logic [DEB_W-1:0] cnt_next;

    // Bring the asynchronous pad level into the clock domain.
    always_ff @(posedge clk_neg_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pad;
            s2 <= s1;
        end
    end

    // Decide the next accepted level and counter value.
    // The >= compare lets a threshold lowered mid-count accept at once, and
    // because the increment only happens while cnt < flt_thresh the counter
    // can never wrap.
    always_comb begin
        q_next   = q;
        cnt_next = cnt;
        if (!flt_en) begin
            q_next   = s2;
            cnt_next = '0;
        end else if (s2 == q) begin
            cnt_next = '0;
        end else if (cnt >= flt_thresh) begin
            q_next   = s2;
            cnt_next = '0;
        end else begin
            cnt_next = cnt + DEB_W'(1);
        end
    end

    // Register the filter state.
    always_ff @(posedge clk_neg_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q   <= 1'b0;
            cnt <= '0;
        end else begin
            q   <= q_next;
            cnt <= cnt_next;
        end
    end

    assign level = q;

`ifdef FGPIO_IN_EDGE_EN

    // Edges are taken from the level about to be registered so that a flag
    // appears on the same clock edge as the new level. Pins driven as
    // outputs never raise flags.
    logic rise_set;
    logic fall_set;
    logic rise_q;
    logic fall_q;

    assign rise_set = q_next & ~q & ~dir;
    assign fall_set = ~q_next & q & ~dir;

    // Sticky flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk_neg_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_set | (rise_q & ~edge_clr);
            fall_q <= fall_set | (fall_q & ~edge_clr);
        end
    end

    assign rise_flag = rise_q;
    assign fall_flag = fall_q;

`else

    // Without edge logic the direction and clear inputs have no consumer.
    logic unused_edge_in;
    assign unused_edge_in = dir ^ edge_clr;

    assign rise_flag = 1'b0;
    assign fall_flag = 1'b0;

`endif

endmodule : fgpio_pin_filter

`default_nettype wire

// File: rtl/fgpio_in_filter.sv
`default_nettype none
// ============================================================================
//  Module      : fgpio_in_filter
//  Description : Input conditioning between the GPIO pads and the FGPIO
//                instruction unit. One fgpio_pin_filter per pin provides
//                synchronisation, debounce and sticky edge flags; this level
//                combines the masked flags into a registered interrupt.
//                Optional feature macro: FGPIO_IN_EDGE_EN (edge flags and
//                irq_o; when undefined they are tied to 0).
//  Revision    : 1.0 - initial release
// ============================================================================

module fgpio_in_filter
    import fgpio_pkg::*;
#(
    parameter int PIN_NUM = PIN_NUM_DEF,
    parameter int DEB_W   = DEB_W_DEF
) (
    input  logic               clk_neg_i,
    input  logic               rst_ni,
    input  logic [PIN_NUM-1:0] pad_in_i,
    input  logic [PIN_NUM-1:0] gpio_dir_i,
    input  logic               flt_en_i,
    input  logic [DEB_W-1:0]   flt_thresh_i,
    output logic [PIN_NUM-1:0] gpio_in_val_o,
    input  logic [PIN_NUM-1:0] rise_en_i,
    input  logic [PIN_NUM-1:0] fall_en_i,
    input  logic [PIN_NUM-1:0] edge_clr_i,
    output logic [PIN_NUM-1:0] rise_flag_o,
    output logic [PIN_NUM-1:0] fall_flag_o,
    output logic               irq_o
);

    logic [PIN_NUM-1:0] level;
    logic [PIN_NUM-1:0] rise_flag;
    logic [PIN_NUM-1:0] fall_flag;

    // One independent conditioner per pin; threshold and enable are shared.
    for (genvar i = 0; i < PIN_NUM; i++) begin : g_pin
        fgpio_pin_filter #(
            .DEB_W      (DEB_W)
        ) u_pin (
            .clk_neg_i  (clk_neg_i),
            .rst_ni     (rst_ni),
            .pad        (pad_in_i[i]),
            .dir        (gpio_dir_i[i]),
            .flt_en     (flt_en_i),
            .flt_thresh (flt_thresh_i),
            .edge_clr   (edge_clr_i[i]),
            .level      (level[i]),
            .rise_flag  (rise_flag[i]),
            .fall_flag  (fall_flag[i])
        );
    end

    assign gpio_in_val_o = level;
    assign rise_flag_o   = rise_flag;
    assign fall_flag_o   = fall_flag;

`ifdef FGPIO_IN_EDGE_EN

    logic irq_q;

    // Level interrupt, registered so it trails the flags by one cycle.
    always_ff @(posedge clk_neg_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |((rise_flag & rise_en_i) | (fall_flag & fall_en_i));
        end
    end

    assign irq_o = irq_q;

`else

    // Interrupt masks have no consumer without edge logic.
    logic unused_irq_in;
    assign unused_irq_in = ^{rise_en_i, fall_en_i};

    assign irq_o = 1'b0;

`endif

endmodule : fgpio_in_filter

`default_nettype wire
